// File: rtl/board_move_engine_if.sv
// Move request / response channel for board_move_engine.
// The master drives moves and the engine answers each accepted transfer.
interface board_move_engine_if #(
  parameter int CW = 2
) ();
  logic          move_valid;
  logic          move_ready;
  logic [CW-1:0] move_row;
  logic [CW-1:0] move_col;
  logic          move_player;
  logic          resp_valid;
  logic [2:0]    resp_code;

  modport master (
    output move_valid, move_row, move_col, move_player,
    input  move_ready, resp_valid, resp_code
  );

  modport slave (
    input  move_valid, move_row, move_col, move_player,
    output move_ready, resp_valid, resp_code
  );
endinterface

// File: rtl/board_move_engine.sv
// N x N board move engine: validates moves, owns the board,
// tracks turn order and detects line wins or a draw.
module board_move_engine #(
  parameter int N   = 3,
  parameter int CW  = $clog2(N+1),
  parameter int MCW = $clog2(N*N+1)
) (
  input  logic               clk,
  input  logic               rst,
  board_move_engine_if.slave mv,
  output logic [2*N*N-1:0]   board_flat,
  output logic               turn,
  output logic [MCW-1:0]     move_count,
  output logic               game_over,
  output logic [1:0]         winner
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    JUDGE
  } state_t;

  localparam logic [2:0] C_ACCEPT = 3'd0;
  localparam logic [2:0] C_OOG    = 3'd1;
  localparam logic [2:0] C_TURN   = 3'd2;
  localparam logic [2:0] C_OCC    = 3'd3;
  localparam logic [2:0] C_OVER   = 3'd4;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic             r_player;
  logic [2*N*N-1:0] r_board;
  logic             r_turn;
  logic [MCW-1:0]   r_count;
  logic             r_over;
  logic [1:0]       r_winner;
  logic             r_resp_valid;
  logic [2:0]       r_resp_code;

  logic       w_ready;
  logic       w_xfer;
  logic       w_in_grid;
  logic [1:0] w_cell;
  logic [1:0] w_mark;
  logic [2:0] w_code;
  logic       w_line;
  logic       w_win;

  assign w_xfer = mv.move_valid & w_ready;
  assign w_mark = {1'b0, r_player};

  // Out-of-grid coordinates must never reach the cell select.
  always_comb begin
    w_in_grid = (r_row < CW'(N)) && (r_col < CW'(N));
    w_cell    = 2'd2;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (w_in_grid && r_row == CW'(r) && r_col == CW'(c))
          w_cell = r_board[2*(r*N+c) +: 2];
  end

  always_comb begin
    w_code = C_ACCEPT;
    if (r_over)
      w_code = C_OVER;
    else if (!w_in_grid)
      w_code = C_OOG;
    else if (r_player != r_turn)
      w_code = C_TURN;
    else if (w_cell != 2'd2)
      w_code = C_OCC;
  end

  always_comb begin
    w_win  = 1'b0;
    w_line = 1'b1;
    for (int r = 0; r < N; r++) begin
      w_line = 1'b1;
      for (int c = 0; c < N; c++)
        w_line &= (r_board[2*(r*N+c) +: 2] == w_mark);
      w_win |= w_line;
    end
    for (int c = 0; c < N; c++) begin
      w_line = 1'b1;
      for (int r = 0; r < N; r++)
        w_line &= (r_board[2*(r*N+c) +: 2] == w_mark);
      w_win |= w_line;
    end
    w_line = 1'b1;
    for (int i = 0; i < N; i++)
      w_line &= (r_board[2*(i*N+i) +: 2] == w_mark);
    w_win |= w_line;
    w_line = 1'b1;
    for (int i = 0; i < N; i++)
      w_line &= (r_board[2*(i*N+N-1-i) +: 2] == w_mark);
    w_win |= w_line;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = ~rst;
        if (w_xfer) w_next = CHECK;
      end
      CHECK:   w_next = (w_code == C_ACCEPT) ? JUDGE : IDLE;
      JUDGE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_player     <= 1'b0;
      r_board      <= {N*N{2'd2}};
      r_turn       <= 1'b0;
      r_count      <= '0;
      r_over       <= 1'b0;
      r_winner     <= 2'd3;
      r_resp_valid <= 1'b0;
      r_resp_code  <= C_ACCEPT;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_xfer) begin
        r_row    <= mv.move_row;
        r_col    <= mv.move_col;
        r_player <= mv.move_player;
      end
      if (r_state == CHECK) begin
        if (w_code != C_ACCEPT) begin
          r_resp_valid <= 1'b1;
          r_resp_code  <= w_code;
        end else begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (r_row == CW'(r) && r_col == CW'(c))
                r_board[2*(r*N+c) +: 2] <= w_mark;
          r_count <= r_count + 1'b1;
        end
      end
      // A win on the final cell takes precedence over the draw.
      if (r_state == JUDGE) begin
        r_resp_valid <= 1'b1;
        r_resp_code  <= C_ACCEPT;
        if (w_win) begin
          r_over   <= 1'b1;
          r_winner <= w_mark;
        end else if (r_count == MCW'(N*N)) begin
          r_over   <= 1'b1;
          r_winner <= 2'd2;
        end else begin
          r_turn <= ~r_turn;
        end
      end
    end
  end

  assign mv.move_ready = w_ready;
  assign mv.resp_valid = r_resp_valid;
  assign mv.resp_code  = r_resp_code;
  assign board_flat    = r_board;
  assign turn          = r_turn;
  assign move_count    = r_count;
  assign game_over     = r_over;
  assign winner        = r_winner;

endmodule
